// File: rtl/cic_interpolator.sv
// Three-stage CIC interpolator: combs at the input rate, zero-stuff by R, integrators at clock rate.
// Define CIC_INTERP_NORM_EN to add a registered, rounded divide by R^(N-1) (unity DC gain) on the output.
module cic_interpolator #(
    parameter int W_IN  = 8,
    parameter int N     = 3,
    parameter int LOG2R = 3,
    parameter int W_OUT = W_IN + (N - 1) * LOG2R
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W_IN-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W_OUT-1:0] out_data,
    output logic             out_valid,
    output logic             underflow,
    input  logic             clr_flags
);

    // Internal width covers the full comb/integrator growth; wrap-around is harmless.
    localparam int WI = W_IN + N * LOG2R;
    localparam logic [LOG2R-1:0] PHASE_ONE = 1;

    logic [LOG2R-1:0] phase;
    logic             slot;
    logic [WI-1:0]    x;
    logic [WI-1:0]    c     [0:N];
    logic [WI-1:0]    d     [1:N];
    logic [WI-1:0]    u;
    logic [WI-1:0]    integ [1:N];

    assign slot     = en && (phase == '0);
    assign in_ready = slot;

    // A missing sample is treated as zero so the comb state stays consistent.
    assign x = in_valid ? {{(WI - W_IN){in_data[W_IN-1]}}, in_data} : '0;

    // NOTE: every element is assigned on every pass, so no latch is inferred.
    always_comb begin
        c[0] = x;
        for (int i = 1; i <= N; i++) begin
            c[i] = c[i-1] - d[i];
        end
    end

    // NOTE: the delay and accumulator arrays are plain registers, not RAM, so they are reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            u         <= '0;
            out_valid <= 1'b0;
            underflow <= 1'b0;
            for (int i = 1; i <= N; i++) begin
                d[i]     <= '0;
                integ[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make every stage read the previous cycle's values.
            out_valid <= en;
            if (en) begin
                phase <= phase + PHASE_ONE;
                if (phase == '0) begin
                    for (int i = 1; i <= N; i++) begin
                        d[i] <= c[i-1];
                    end
                    u <= c[N];
                end else begin
                    u <= '0;
                end

                integ[1] <= integ[1] + u;
                for (int i = 2; i <= N; i++) begin
                    integ[i] <= integ[i] + integ[i-1];
                end

                if ((phase == '0) && !in_valid) begin
                    underflow <= 1'b1;
                end else if (clr_flags) begin
                    underflow <= 1'b0;
                end
            end
        end
    end

`ifdef CIC_INTERP_NORM_EN
    localparam int SH = (N - 1) * LOG2R;
    localparam logic [WI-1:0] HALF = {{(WI - SH){1'b0}}, 1'b1, {(SH - 1){1'b0}}};

    logic signed [WI-1:0] rsum;
    logic [W_OUT-1:0]     norm_q;

    // Round half up, then drop the R^(N-1) gain with an arithmetic shift.
    assign rsum = integ[N] + HALF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_q <= '0;
        end else if (en) begin
            norm_q <= W_OUT'(rsum >>> SH);
        end
    end

    assign out_data = norm_q;
`else
    assign out_data = integ[N][W_OUT-1:0];
`endif

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator: reference is the zero-stuffed input convolved
// with the CIC impulse response (three length-R boxcars), indexed by enabled clock edges.
module tb_cic_interpolator;

    localparam int W_IN  = 8;
    localparam int N     = 3;
    localparam int LOG2R = 3;
    localparam int R     = 8;
    localparam int W_OUT = 14;
    localparam int HLEN  = N * (R - 1) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [W_IN-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [W_OUT-1:0] out_data;
    logic             out_valid;
    logic             underflow;
    logic             clr_flags;

    cic_interpolator #(.W_IN(W_IN), .N(N), .LOG2R(LOG2R), .W_OUT(W_OUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underflow (underflow),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   h [HLEN];
    int   v [8192];
    int   ecount;
    logic m_und;
    logic m_ov;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int y_at(input int idx);
        int s = 0;
        for (int j = 0; j < HLEN; j++) begin
            if (idx - j >= 0) s += h[j] * v[idx - j];
        end
        return s;
    endfunction

    // Output after the E-th enabled edge reflects samples up to enabled edge E-3.
    function automatic int exp_out();
`ifdef CIC_INTERP_NORM_EN
        return (y_at(ecount - 5) + 32) >>> 6;
`else
        return y_at(ecount - 4);
`endif
    endfunction

    task automatic cycle(input logic e, input logic val, input int d, input logic clr);
        logic slot;
        en        = e;
        in_valid  = val;
        in_data   = d[7:0];
        clr_flags = clr;
        slot = e && (ecount % R == 0);
        #1;
        check("in_ready", in_ready, slot);
        @(posedge clk);
        #1;
        if (e) begin
            v[ecount] = (slot && val) ? d : 0;
            ecount++;
            if (slot && !val) m_und = 1'b1;
            else if (clr)     m_und = 1'b0;
        end
        m_ov = e;
        check("out_valid", out_valid, m_ov);
        check("underflow", underflow, m_und);
        check("out_data", $signed(out_data), exp_out());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_data", $signed(out_data), 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_underflow", underflow, 0);
        check("rst_in_ready", in_ready, en);
        ecount = 0;
        m_und  = 1'b0;
        m_ov   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_out_data", $signed(out_data), 0);
        rst_n = 1'b1;
    endtask

    task automatic pad_to_slot();
        while (ecount % R != 0) cycle(1'b1, 1'b1, 0, 1'b0);
    endtask

    initial begin
        int a [HLEN];
        int b [HLEN];
        int len;
        int obs [41];
        int sum;
        int nz;
        int first;
        int nv;

        // Impulse response = three cascaded length-R boxcars.
        for (int i = 0; i < HLEN; i++) a[i] = 0;
        a[0] = 1;
        len  = 1;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < HLEN; i++) b[i] = 0;
            for (int i = 0; i < len; i++)
                for (int k = 0; k < R; k++) b[i + k] += a[i];
            a = b;
            len += R - 1;
        end
        h = a;

        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; clr_flags = 1'b0;
        ecount = 0; m_und = 1'b0; m_ov = 1'b0;
        #3;
        do_reset();

        // Steps: +100 then -128 on every slot.
        repeat (12 * R) cycle(1'b1, 1'b1, 100, 1'b0);
`ifdef CIC_INTERP_NORM_EN
        check("step_pos", $signed(out_data), 100);
`else
        check("step_pos", $signed(out_data), 6400);
`endif
        repeat (12 * R) cycle(1'b1, 1'b1, -128, 1'b0);
`ifdef CIC_INTERP_NORM_EN
        check("step_neg", $signed(out_data), -128);
`else
        check("step_neg", $signed(out_data), -8192);
`endif

        // Reset mid-stream with full accumulators, then impulse.
        do_reset();
        cycle(1'b1, 1'b1, 1, 1'b0);
        obs[0] = $signed(out_data);
        for (int i = 1; i < 41; i++) begin
            cycle(1'b1, 1'b1, 0, 1'b0);
            obs[i] = $signed(out_data);
        end
`ifndef CIC_INTERP_NORM_EN
        sum = 0; nz = 0; first = -1;
        for (int i = 0; i < 41; i++) begin
            sum += obs[i];
            if (obs[i] != 0) begin
                nz++;
                if (first < 0) first = i;
            end
        end
        check("impulse_sum", sum, 512);
        check("impulse_len", nz, HLEN);
        check("impulse_first_idx", first, 3);
        check("impulse_first_val", obs[3], 1);
        for (int i = 0; i < HLEN / 2; i++)
            check("impulse_symmetry", obs[3 + i], obs[3 + HLEN - 1 - i] + 0 * i);
`endif

        // Underflow: missed slot, sticky, clear, set-wins, held while disabled.
        pad_to_slot();
        cycle(1'b1, 1'b0, 55, 1'b0);
        repeat (2 * R) cycle(1'b1, 1'b1, $urandom_range(0, 255) - 128, 1'b0);
        check("underflow_sticky", underflow, 1);
        cycle(1'b1, 1'b1, 3, 1'b1);
        check("underflow_cleared", underflow, 0);
        pad_to_slot();
        cycle(1'b1, 1'b0, 0, 1'b1);
        check("underflow_set_wins", underflow, 1);
        repeat (3) cycle(1'b0, 1'b1, 0, 1'b1);
        check("underflow_held_disabled", underflow, 1);
        cycle(1'b1, 1'b1, 0, 1'b1);
        repeat (R) cycle(1'b1, 1'b1, 7, 1'b0);

        // Enable gating with a ramp; one out_valid per enabled edge.
        do_reset();
        nv = 0;
        while (ecount < 200) begin
            cycle(($urandom_range(0, 2) != 0), 1'b1, (ecount / R) * 5 - 50, 1'b0);
            if (out_valid === 1'b1) nv++;
        end
        check("gate_valid_count", nv, ecount);

        // Full-scale alternating +127/-128 per slot.
        do_reset();
        for (int s = 0; s < 200; s++)
            for (int p = 0; p < R; p++)
                cycle(1'b1, 1'b1, (s % 2 != 0) ? -128 : 127, 1'b0);
        repeat (30) cycle(1'b1, 1'b1, 0, 1'b0);

        // Random mix of enable, valid, data and clear.
        repeat (300)
            cycle(($urandom_range(0, 4) != 0), ($urandom_range(0, 7) != 0),
                  $urandom_range(0, 255) - 128, ($urandom_range(0, 9) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Three-stage CIC interpolation filter that raises a low-rate signed sample stream by a factor R to one output sample per clock. It is the transmit-side counterpart of the CIC decimation path in `tt_um_cic_filter_demo`: comb stages run at the input rate, zero-stuffing upsamples, and integrators run at the clock rate. It sits between a sample source (pattern generator / `ui_in` capture) and a DAC/PDM output stage.

## Interface
- `W_IN`, 8, signed input sample width
- `N`, 3, number of comb and integrator stages (fixed at 3 for this release)
- `LOG2R`, 3, log2 of interpolation ratio R (R = 8)
- `W_OUT`, W_IN+(N-1)*LOG2R = 14, output width (exact DC gain R^(N-1) = 64)
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  global enable; low freezes every register (phase, combs, integrators, flags)
- `in_data`  in  W_IN  signed two's-complement input sample
- `in_valid`  in  1  source has a sample
- `in_ready`  out  1  block accepts a sample this cycle
- `out_data`  out  W_OUT  signed interpolated output
- `out_valid`  out  1  out_data is a new sample this cycle
- `underflow`  out  1  sticky: an input slot passed with no sample
- `clr_flags`  in  1  synchronous clear of `underflow`

## Operation
- Phase counter `phase` (LOG2R bits) increments by 1 every cycle with `en`=1, wraps R-1 -> 0.
- `in_ready` = `en` && `phase`==0 (combinational). Accept = `in_valid` && `in_ready`.
- Input slot (`phase`==0, `en`=1): x = `in_data` if `in_valid`, else x = 0 and `underflow` set to 1. Comb delay registers always update in the slot (with x=0 on underflow).
- Comb chain (combinational, M=1): c0 = x, ci = c(i-1) - d_i, d_i <= c(i-1) in the slot. Internal width WI = W_IN + N*LOG2R = 17 bits, sign-extended input, modular arithmetic.
- Upsample register `u` <= c3 in the slot, <= 0 on all other enabled cycles.
- Integrators (registered, pipelined): I1 <= I1+u; I2 <= I2+I1; I3 <= I3+I2, all WI bits, wrap-around two's complement (wrap is intended; final result is exact).
- `out_data` = I3[W_OUT-1:0] (exact, no truncation error) — see Configuration.
- `out_valid` <= `en` (registered), so it is high on every cycle following an enabled edge.
- `underflow`: set on an unfilled slot; `clr_flags` clears; set wins if both in the same cycle. Held while `en`=0.

## Timing
- Reset (async, `rst_n`=0): phase=0, d_i=0, u=0, I1..I3=0, `out_data`=0, `out_valid`=0, `underflow`=0. `in_ready` = `en` immediately after reset release.
- Latency: sample accepted at edge k -> u at k, I1 at k+1, I2 at k+2, I3/`out_data` first reflects it after edge k+3.
- Throughput: exactly one input per R enabled cycles; one output per enabled cycle.
- `en` low mid-slot: `in_ready` low, no accept, no underflow, all state held; resumes identically.
- Reset mid-stream: all accumulators cleared, next slot is phase 0 on first enabled edge.

## Configuration
- `CIC_INTERP_NORM_EN` defined: `out_data` = (I3 + 2^((N-1)*LOG2R-1)) >>> ((N-1)*LOG2R) (round half up, unity DC gain), sign-extended to W_OUT; adds one register stage (latency +1 cycle, reset value 0).
- Not defined: `out_data` = raw I3 low W_OUT bits, gain 64, latency as above.

## Test plan
- Reset: drive rst_n=0 mid-operation with nonzero state -> all outputs 0 same cycle; after release, in_ready high at phase 0 only, every 8th enabled cycle.
- Step: in_data=100 every slot -> out_data settles to 6400 (norm: 100) and stays constant; in_data=-128 -> -8192 (norm: -128).
- Impulse: single sample 1 then zeros -> out_data nonzero for 22 cycles, sum of all outputs = 512, symmetric shape, first nonzero output (value 1) 3 cycles after accept edge.
- Underflow: hold in_valid=0 across one slot -> underflow=1 and stays; output equals response with a zero sample; clr_flags pulse -> 0; simultaneous clr and missed slot -> stays 1.
- Enable gating: toggle en randomly during a ramp input -> output sequence (taken on out_valid) identical to the en=1 run.
- Full scale alternating +127/-128 each slot for 200 slots -> output matches software reference model bit-exactly, no overflow artifacts.
